// File: rtl/ifu_redirect_arb_pkg.sv
// rtl/ifu_redirect_arb_pkg.sv - shared config constants and types for the IFU redirect arbiter
package ifu_redirect_arb_pkg;

    localparam int IFU_XLEN_DEF    = 32;
    localparam int IFU_NSRC_DEF    = 4;
    localparam int IFU_EPOCH_W_DEF = 3;

    // Source 0 is the execution unit (highest priority); the last source is the branch predictor.
    localparam int SRC_EXU = 0;

    function automatic int src_bpu(input int nsrc);
        return nsrc - 1;
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ifu_redirect_arb_if.sv
// rtl/ifu_redirect_arb_if.sv - redirect request/response bundle between sources and the PC stage
interface ifu_redirect_arb_if
    import ifu_redirect_arb_pkg::*;
#(
    parameter int XLEN    = IFU_XLEN_DEF,
    parameter int NSRC    = IFU_NSRC_DEF,
    parameter int EPOCH_W = IFU_EPOCH_W_DEF
);
    logic [NSRC-1:0]      req;
    logic [NSRC*XLEN-1:0] addr;
    logic                 pc_ready;
    logic                 flush;
    logic                 jump;
    logic [XLEN-1:0]      jump_addr;
    logic [NSRC-1:0]      jump_src;
    logic [NSRC-1:0]      drop;
    logic [EPOCH_W-1:0]   epoch;

    // Requesters and the PC stage drive the inputs and observe the arbiter decision.
    modport master (
        output req, addr, pc_ready, flush,
        input  jump, jump_addr, jump_src, drop, epoch
    );

    modport slave (
        input  req, addr, pc_ready, flush,
        output jump, jump_addr, jump_src, drop, epoch
    );
endinterface

// File: rtl/ifu_prio_sel.sv
// rtl/ifu_prio_sel.sv - fixed-priority selector, lowest index wins
module ifu_prio_sel #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Scan from the top down so the lowest asserted index is the last one written.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                grant_o    = '0;
                grant_o[k] = 1'b1;
                idx_o      = IW'(k);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/ifu_redirect_arb.sv
// rtl/ifu_redirect_arb.sv - priority arbiter presenting one fetch redirect per cycle with hold/replace
module ifu_redirect_arb
    import ifu_redirect_arb_pkg::*;
#(
    parameter int XLEN    = IFU_XLEN_DEF,
    parameter int NSRC    = IFU_NSRC_DEF,
    parameter int EPOCH_W = IFU_EPOCH_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic [NSRC-1:0]      i_req,
    input  logic [NSRC*XLEN-1:0] i_addr,
    input  logic                 i_pc_ready,
    input  logic                 i_flush,
    output logic                 o_jump,
    output logic [XLEN-1:0]      o_jump_addr,
    output logic [NSRC-1:0]      o_jump_src,
    output logic [NSRC-1:0]      o_drop,
    output logic [EPOCH_W-1:0]   o_epoch
);

    localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    arb_state_e         state_q;
    logic [IDX_W-1:0]   held_idx_q;
    logic [XLEN-1:0]    held_addr_q;
    logic [EPOCH_W-1:0] epoch_q;

    logic [NSRC-1:0]    live_grant;
    logic [IDX_W-1:0]   live_idx;
    logic               live_any;
    logic [XLEN-1:0]    live_addr;

    logic               use_live;
    logic               pres_valid;
    logic [IDX_W-1:0]   pres_idx;
    logic [XLEN-1:0]    pres_addr;
    logic [NSRC-1:0]    pres_src;
    logic [NSRC-1:0]    held_src;

    ifu_prio_sel #(.N(NSRC)) u_live_sel (
        .req_i   (i_req),
        .grant_o (live_grant),
        .idx_o   (live_idx),
        .any_o   (live_any)
    );

    // Pick the winner's target with a one-hot AND-OR mux driven by the grant.
    always_comb begin
        live_addr = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (live_grant[k]) begin
                live_addr = i_addr[k*XLEN +: XLEN];
            end
        end
    end

    // Decide what is shown to the PC stage; a live request at equal or higher priority
    // than the held one overrides it. Nothing here depends on i_pc_ready.
    always_comb begin
        held_src   = '0;
        held_src[held_idx_q] = 1'b1;
        use_live   = live_any && ((state_q == ST_IDLE) || (live_idx <= held_idx_q));
        pres_valid = live_any || (state_q == ST_HOLD);
        pres_idx   = use_live ? live_idx   : held_idx_q;
        pres_addr  = use_live ? live_addr  : held_addr_q;
        pres_src   = use_live ? live_grant : held_src;
    end

    // Flush suppresses the redirect and discards every live request; otherwise anything
    // not being presented this cycle is reported as dropped.
    always_comb begin
        o_jump      = pres_valid && !i_flush;
        o_jump_addr = pres_addr;
        o_jump_src  = o_jump ? pres_src : '0;
        o_drop      = i_flush ? i_req : (i_req & ~(use_live ? live_grant : '0));
    end

    assign o_epoch = epoch_q;

    // Hold/accept state machine; flush outranks acceptance and capture.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= ST_IDLE;
            held_idx_q  <= '0;
            held_addr_q <= '0;
            epoch_q     <= '0;
        end else if (i_flush) begin
            state_q     <= ST_IDLE;
            held_idx_q  <= '0;
            held_addr_q <= '0;
        end else if (o_jump && i_pc_ready) begin
            state_q     <= ST_IDLE;
            held_idx_q  <= '0;
            held_addr_q <= '0;
            epoch_q     <= epoch_q + EPOCH_W'(1);
        end else if (o_jump) begin
            state_q     <= ST_HOLD;
            held_idx_q  <= pres_idx;
            held_addr_q <= pres_addr;
        end
    end

endmodule

// File: tb/tb_ifu_redirect_arb.sv
// tb/tb_ifu_redirect_arb.sv - self-checking bench for ifu_redirect_arb
module tb_ifu_redirect_arb;
    import ifu_redirect_arb_pkg::*;

    localparam int XLEN = 32;
    localparam int NSRC = 4;
    localparam int EW   = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ifu_redirect_arb_if #(.XLEN(XLEN), .NSRC(NSRC), .EPOCH_W(EW)) ifc ();

    ifu_redirect_arb #(.XLEN(XLEN), .NSRC(NSRC), .EPOCH_W(EW)) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_req       (ifc.req),
        .i_addr      (ifc.addr),
        .i_pc_ready  (ifc.pc_ready),
        .i_flush     (ifc.flush),
        .o_jump      (ifc.jump),
        .o_jump_addr (ifc.jump_addr),
        .o_jump_src  (ifc.jump_src),
        .o_drop      (ifc.drop),
        .o_epoch     (ifc.epoch)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a pending redirect is either absent or (source, target).
    bit              m_hold;
    int              m_idx;
    logic [XLEN-1:0] m_addr;
    int              m_epoch;

    logic            e_jump;
    logic [XLEN-1:0] e_addr;
    logic [NSRC-1:0] e_src;
    logic [NSRC-1:0] e_drop;
    int              e_pidx;

    function automatic void model_eval();
        int win;
        logic [NSRC-1:0] one;
        one    = 1;
        win    = -1;
        for (int k = 0; k < NSRC; k++) if (ifc.req[k] && win < 0) win = k;
        e_jump = 1'b0;
        e_addr = '0;
        e_src  = '0;
        e_drop = ifc.req;
        e_pidx = 0;
        if (ifc.flush) return;
        if (win >= 0 && (!m_hold || win <= m_idx)) begin
            e_jump = 1'b1;
            e_pidx = win;
            e_addr = ifc.addr[win*XLEN +: XLEN];
            e_src  = one << win;
            e_drop = ifc.req & ~e_src;
        end else if (m_hold) begin
            e_jump = 1'b1;
            e_pidx = m_idx;
            e_addr = m_addr;
            e_src  = one << m_idx;
        end
    endfunction

    function automatic void model_tick();
        if (ifc.flush) begin
            m_hold = 1'b0;
        end else if (e_jump && ifc.pc_ready) begin
            m_hold  = 1'b0;
            m_epoch = (m_epoch + 1) % (1 << EW);
        end else if (e_jump) begin
            m_hold = 1'b1;
            m_idx  = e_pidx;
            m_addr = e_addr;
        end
    endfunction

    task automatic drive(input logic [NSRC-1:0] req, input logic [XLEN-1:0] a0, a1, a2, a3,
                         input logic rdy, input logic fl);
        ifc.req      = req;
        ifc.addr     = {a3, a2, a1, a0};
        ifc.pc_ready = rdy;
        ifc.flush    = fl;
        @(negedge clk);
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        if (rstn) model_tick();
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        drive('0, '0, '0, '0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rstn    = 1'b1;
        m_hold  = 1'b0;
        m_idx   = 0;
        m_addr  = '0;
        m_epoch = 0;
    endtask

    task automatic test_reset();
        do_reset();
        drive('0, '0, '0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (ifc.jump !== 1'b0 || ifc.jump_src !== 4'b0 || ifc.drop !== 4'b0 || ifc.epoch !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: jump=%b src=%b drop=%b epoch=%0d, want 0 0000 0000 0",
                     ifc.jump, ifc.jump_src, ifc.drop, ifc.epoch);
        end
        tick();
    endtask

    task automatic test_single();
        drive(4'b1000, '0, '0, '0, 32'h100, 1'b1, 1'b0);
        checks++;
        if (ifc.jump !== 1'b1 || ifc.jump_addr !== 32'h100 || ifc.jump_src !== 4'b1000) begin
            errors++;
            $display("FAIL single_present: jump=%b addr=%h src=%b, want 1 00000100 1000",
                     ifc.jump, ifc.jump_addr, ifc.jump_src);
        end
        tick();
        drive('0, '0, '0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (ifc.epoch !== 3'd1 || ifc.jump !== 1'b0) begin
            errors++;
            $display("FAIL single_epoch: epoch=%0d jump=%b, want 1 0", ifc.epoch, ifc.jump);
        end
        tick();
    endtask

    task automatic test_priority_drop();
        drive(4'b1001, 32'h200, '0, '0, 32'h300, 1'b1, 1'b0);
        checks++;
        if (ifc.jump_addr !== 32'h200 || ifc.jump_src !== 4'b0001 || ifc.drop !== 4'b1000) begin
            errors++;
            $display("FAIL prio_drop: addr=%h src=%b drop=%b, want 00000200 0001 1000",
                     ifc.jump_addr, ifc.jump_src, ifc.drop);
        end
        tick();
    endtask

    task automatic test_replace();
        drive(4'b1000, '0, '0, '0, 32'h300, 1'b0, 1'b0);
        checks++;
        if (ifc.jump !== 1'b1 || ifc.jump_addr !== 32'h300 || ifc.drop !== 4'b0) begin
            errors++;
            $display("FAIL replace_first: jump=%b addr=%h drop=%b, want 1 00000300 0000",
                     ifc.jump, ifc.jump_addr, ifc.drop);
        end
        tick();
        drive(4'b0001, 32'h400, '0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (ifc.jump_addr !== 32'h400 || ifc.jump_src !== 4'b0001 || ifc.drop !== 4'b0 || ifc.epoch !== 3'd2) begin
            errors++;
            $display("FAIL replace_live: addr=%h src=%b drop=%b epoch=%0d, want 00000400 0001 0000 2",
                     ifc.jump_addr, ifc.jump_src, ifc.drop, ifc.epoch);
        end
        tick();
        drive('0, '0, '0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (ifc.jump !== 1'b0 || ifc.epoch !== 3'd3) begin
            errors++;
            $display("FAIL replace_epoch: jump=%b epoch=%0d, want 0 3", ifc.jump, ifc.epoch);
        end
        tick();
    endtask

    task automatic test_hold_drop();
        drive(4'b0010, '0, 32'h500, '0, '0, 1'b0, 1'b0);
        tick();
        drive(4'b1000, '0, '0, '0, 32'h999, 1'b0, 1'b0);
        checks++;
        if (ifc.jump !== 1'b1 || ifc.jump_addr !== 32'h500 || ifc.jump_src !== 4'b0010 || ifc.drop !== 4'b1000) begin
            errors++;
            $display("FAIL hold_drop: jump=%b addr=%h src=%b drop=%b, want 1 00000500 0010 1000",
                     ifc.jump, ifc.jump_addr, ifc.jump_src, ifc.drop);
        end
        tick();
        drive('0, '0, '0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (ifc.jump !== 1'b1 || ifc.jump_addr !== 32'h500 || ifc.jump_src !== 4'b0010 || ifc.drop !== 4'b0) begin
            errors++;
            $display("FAIL hold_kept: jump=%b addr=%h src=%b drop=%b, want 1 00000500 0010 0000",
                     ifc.jump, ifc.jump_addr, ifc.jump_src, ifc.drop);
        end
        tick();
        drive('0, '0, '0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (ifc.jump !== 1'b0 || ifc.epoch !== 3'd4) begin
            errors++;
            $display("FAIL hold_accept: jump=%b epoch=%0d, want 0 4", ifc.jump, ifc.epoch);
        end
        tick();
    endtask

    task automatic test_flush();
        drive(4'b0100, '0, '0, 32'h600, '0, 1'b0, 1'b0);
        tick();
        drive(4'b0001, 32'h700, '0, '0, '0, 1'b1, 1'b1);
        checks++;
        if (ifc.jump !== 1'b0 || ifc.jump_src !== 4'b0 || ifc.drop !== 4'b0001) begin
            errors++;
            $display("FAIL flush_cycle: jump=%b src=%b drop=%b, want 0 0000 0001",
                     ifc.jump, ifc.jump_src, ifc.drop);
        end
        tick();
        drive('0, '0, '0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (ifc.jump !== 1'b0 || ifc.epoch !== 3'd4) begin
            errors++;
            $display("FAIL flush_after: jump=%b epoch=%0d, want 0 4", ifc.jump, ifc.epoch);
        end
        tick();
    endtask

    task automatic test_epoch_wrap();
        int k;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            k = $urandom_range(0, NSRC - 1);
            drive(4'(1 << k), $urandom, $urandom, $urandom, $urandom, 1'b1, 1'b0);
            tick();
        end
        drive('0, '0, '0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (ifc.epoch !== 3'd0) begin
            errors++;
            $display("FAIL epoch_wrap: epoch=%0d, want 0", ifc.epoch);
        end
        drive(4'b0100, '0, '0, 32'h800, '0, 1'b0, 1'b0);
        tick();
        rstn = 1'b0;
        drive('0, '0, '0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (ifc.drop !== 4'b0) begin
            errors++;
            $display("FAIL reset_in_hold_drop: drop=%b, want 0000", ifc.drop);
        end
        @(posedge clk);
        #1;
        rstn    = 1'b1;
        m_hold  = 1'b0;
        m_epoch = 0;
        drive('0, '0, '0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (ifc.jump !== 1'b0 || ifc.epoch !== 3'd0 || ifc.drop !== 4'b0) begin
            errors++;
            $display("FAIL reset_in_hold: jump=%b epoch=%0d drop=%b, want 0 0 0000",
                     ifc.jump, ifc.epoch, ifc.drop);
        end
        tick();
    endtask

    task automatic test_random();
        logic [NSRC-1:0] r;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            r = ($urandom_range(0, 3) == 0) ? '0 : NSRC'($urandom_range(0, 15));
            drive(r, $urandom, $urandom, $urandom, $urandom,
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) == 0));
            model_eval();
            checks++;
            if (ifc.jump !== e_jump || ifc.jump_src !== e_src || ifc.drop !== e_drop ||
                ifc.epoch !== EW'(m_epoch) || (e_jump && ifc.jump_addr !== e_addr)) begin
                errors++;
                $display("FAIL random[%0d]: jump=%b addr=%h src=%b drop=%b epoch=%0d, want %b %h %b %b %0d",
                         i, ifc.jump, ifc.jump_addr, ifc.jump_src, ifc.drop, ifc.epoch,
                         e_jump, e_addr, e_src, e_drop, m_epoch);
            end
            if (ifc.jump === 1'b1) begin
                checks++;
                if ($countones(ifc.jump_src) != 1) begin
                    errors++;
                    $display("FAIL random_onehot[%0d]: src=%b, want one-hot", i, ifc.jump_src);
                end
            end
            tick();
        end
    endtask

    initial begin
        ifc.req      = '0;
        ifc.addr     = '0;
        ifc.pc_ready = 1'b0;
        ifc.flush    = 1'b0;
        test_reset();
        test_single();
        test_priority_drop();
        test_replace();
        test_hold_drop();
        test_flush();
        test_epoch_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_redirect_arb.md
IFU_REDIRECT_ARB -- requirements
Module: ifu_redirect_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32, redirect address width.
REQ-002 SHALL have parameter NSRC, default 4, number of redirect sources; index 0 is highest priority (EXU), NSRC-1 lowest (BPU).
REQ-003 SHALL have parameter EPOCH_W, default 3, fetch-epoch counter width.
REQ-004 SHALL have port i_clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port i_rstn  in  1  synchronous, active-low reset.
REQ-006 SHALL have port i_req  in  NSRC  per-source redirect request, one bit per source.
REQ-007 SHALL have port i_addr  in  NSRC*XLEN  per-source target; source k occupies bits [k*XLEN +: XLEN].
REQ-008 SHALL have port i_pc_ready  in  1  PC stage accepts a redirect this cycle.
REQ-009 SHALL have port i_flush  in  1  discard any held redirect (e.g. trap entry handled elsewhere).
REQ-010 SHALL have port o_jump  out  1  redirect valid to PC stage.
REQ-011 SHALL have port o_jump_addr  out  XLEN  redirect target.
REQ-012 SHALL have port o_jump_src  out  NSRC  one-hot source of the presented redirect; zero when o_jump=0.
REQ-013 SHALL have port o_drop  out  NSRC  one-cycle pulse per source whose request was discarded.
REQ-014 SHALL have port o_epoch  out  EPOCH_W  fetch epoch; increments once per accepted redirect.

Function
REQ-015 SHALL select, each cycle, the live winner as the lowest-index asserted i_req bit.
REQ-016 SHALL implement two states: IDLE (no held redirect) and HOLD (held source index, address registered).
REQ-017 In IDLE, SHALL present the live winner combinationally (zero latency): o_jump=|i_req, o_jump_addr/o_jump_src from the winner.
REQ-018 In IDLE with o_jump=1 and i_pc_ready=0, SHALL register the winner and go to HOLD.
REQ-019 In HOLD, SHALL present the held redirect unless a live request has index <= held index, in which case the live winner is presented and replaces the held entry (same index = newer, overrides).
REQ-020 In HOLD, live requests with index > held index SHALL be discarded and flagged on o_drop that cycle.
REQ-021 In IDLE, non-winning asserted requests SHALL be discarded and flagged on o_drop.
REQ-022 On o_jump=1 and i_pc_ready=1, SHALL go to IDLE next cycle and increment o_epoch modulo 2^EPOCH_W.
REQ-023 If i_flush=1, SHALL go to IDLE next cycle, clear held entry, leave o_epoch unchanged, and suppress o_jump that cycle; live requests that cycle are dropped (o_drop set).
REQ-024 i_flush SHALL take precedence over i_pc_ready and over capture.
REQ-025 A held entry SHALL never be lost without either acceptance, replacement by higher/equal priority, or i_flush.
REQ-026 o_jump_src SHALL be exactly one-hot whenever o_jump=1.

Reset
REQ-027 While i_rstn=0 at a rising edge, SHALL enter IDLE, clear held index/address to 0, and set o_epoch to 0.
REQ-028 After reset, outputs SHALL follow inputs per REQ-017 (o_jump=0, o_jump_src=0, o_drop=0 when i_req=0).
REQ-029 Reset asserted in HOLD SHALL discard the held redirect with no o_drop pulse.

Structure
REQ-030 XLEN default and the EPOCH_W default SHALL come from the shared config include; source-index constants (SRC_EXU=0, SRC_BPU=NSRC-1) SHALL live in that shared file.
REQ-031 The priority selector SHALL be a sub-module ifu_prio_sel (parameter N; input request vector; output one-hot grant and binary index) reused for live selection.
REQ-032 No combinational path SHALL exist from i_pc_ready to o_jump or o_jump_addr.

Verification
REQ-033 Reset then i_req=4'b1000, addr3=0x100, i_pc_ready=1 -> same cycle o_jump=1, addr 0x100, src 4'b1000; next cycle o_epoch=1.
REQ-034 i_req=4'b1001 (addr0=0x200, addr3=0x300), ready=1 -> addr 0x200, src 4'b0001, o_drop=4'b1000.
REQ-035 i_req=4'b1000 addr 0x300 with ready=0, next cycle i_req=4'b0001 addr 0x400 ready=1 -> HOLD replaced, addr 0x400 presented and accepted, epoch +1 only once.
REQ-036 HOLD on source 1 (0x500, ready=0); next cycle i_req=4'b1000 ready=0 -> o_drop=4'b1000, held 0x500 still presented next cycle.
REQ-037 HOLD then i_flush=1 with ready=1 -> o_jump=0 that cycle, IDLE next, epoch unchanged.
REQ-038 EPOCH_W=3: eight accepted redirects from epoch 0 -> o_epoch wraps to 0; reset asserted while in HOLD -> IDLE, epoch 0, no o_drop.
